// File: rtl/eth_pcs_params_pkg.sv
// Shared 10GBASE-R PCS constants used by the 66/64 encoder/decoder and the
// TX/RX gearboxes.
//
// W_DATA      payload / PMA word width (64 only)
// W_SYNC      sync header width
// W_BLOCK     full 66-bit block width
// N_GRBX_SEQ  gearbox period in output words (33)
// SEQ_W       width of the gearbox sequence counter
// SEQ_LAST    counter value of the pause (flush) cycle
// SYNC_DATA   sync header of a data block
// SYNC_CTRL   sync header of a control block
package eth_pcs_params;

    localparam int W_DATA     = 64;
    localparam int W_SYNC     = 2;
    localparam int W_BLOCK    = W_DATA + W_SYNC;
    localparam int N_GRBX_SEQ = 33;
    localparam int SEQ_W      = $clog2(N_GRBX_SEQ);

    localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(N_GRBX_SEQ - 1);
    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/eth_pcs_tx_gearbox.sv
// 10GBASE-R TX gearbox: packs one 66-bit block {data, hdr} per enabled cycle
// into a gap-free stream of 64-bit PMA words, LSB (header) first. Every 33rd
// output word carries only the accumulated residual, and upstream is stalled
// for that cycle through o_clk_en.
//
// Ports:
//   i_clk        PCS TX clock (PMA word rate)
//   i_reset      synchronous, active-high reset
//   i_grbx_hdr   sync header of the current block (bits 1:0 of the block)
//   i_grbx_data  scrambled payload of the current block (bits 65:2)
//   o_clk_en     high = the block on i_grbx_* is consumed at this edge
//   o_pma_data   PMA word, bit 0 transmitted first
module eth_pcs_tx_gearbox
    import eth_pcs_params::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [W_SYNC-1:0] i_grbx_hdr,
    input  logic [W_DATA-1:0] i_grbx_data,
    output logic              o_clk_en,
    output logic [W_DATA-1:0] o_pma_data
);

    // Registered state: sequence position, LSB-aligned leftover bits
    // (2*seq of them, zero above), run flag and the output word.
    logic [SEQ_W-1:0]  seq;
    logic [W_DATA-1:0] residual;
    logic              run;
    logic [W_DATA-1:0] pma_data;

    logic              wrap;
    logic [5:0]        offset;
    logic [W_DATA-1:0] word_next;
    logic [W_DATA-1:0] residual_next;
    logic [SEQ_W-1:0]  seq_next;

    assign wrap     = (seq == SEQ_LAST);
    // Decoded purely from registers: no input-to-o_clk_en path.
    assign o_clk_en = run && !wrap;
    // Number of residual bits in front of the new block: 2*seq, 0..62.
    assign offset   = {seq[4:0], 1'b0};

    always_comb begin
        word_next     = pma_data;
        residual_next = residual;
        seq_next      = seq;
        if (run) begin
            if (wrap) begin
                // Residual is exactly 64 bits here; flush it and start over.
                word_next     = residual;
                residual_next = '0;
                seq_next      = '0;
            end else begin
                // Low 64 bits of {block, residual[offset-1:0]}. The residual
                // is zero above its valid bits, so a plain OR merges them.
                word_next = ({i_grbx_data[W_DATA-W_SYNC-1:0], i_grbx_hdr} << offset)
                            | residual;
                // Upper offset+2 bits of the block = top bits of the payload,
                // shifted down to bit 0. Shift range stays within 0..62.
                residual_next = i_grbx_data >> (6'd62 - offset);
                seq_next      = seq + SEQ_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            seq      <= '0;
            residual <= '0;
            run      <= 1'b0;
            pma_data <= '0;
        end else begin
            run      <= 1'b1;
            seq      <= seq_next;
            residual <= residual_next;
            pma_data <= word_next;
        end
    end

    assign o_pma_data = pma_data;

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
module tb_eth_pcs_tx_gearbox;

    logic        clk;
    logic        i_reset;
    logic [1:0]  i_grbx_hdr;
    logic [63:0] i_grbx_data;
    logic        o_clk_en;
    logic [63:0] o_pma_data;

    int total = 0;
    int bad   = 0;

    eth_pcs_tx_gearbox dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_grbx_hdr  (i_grbx_hdr),
        .i_grbx_data (i_grbx_data),
        .o_clk_en    (o_clk_en),
        .o_pma_data  (o_pma_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Bit-stream model: every consumed block appends its 66 bits (header
    // first) to a serial queue; every output word after the first run cycle
    // takes the next 64 bits. Consumption happens on all run cycles except
    // the last of each 33.
    bit          q[$];
    int          n_run = 0;      // edges seen since reset released
    logic [63:0] exp_data = '0;
    logic        exp_en = 1'b0;
    bit          started = 0;

    always @(posedge clk) begin
        if (i_reset) begin
            q.delete();
            n_run    = 0;
            exp_data = '0;
            exp_en   = 1'b0;
            started  = 1;
        end else begin
            if (n_run >= 1) begin
                if (((n_run - 1) % 33) != 32) begin
                    for (int b = 0; b < 2; b++)  q.push_back(i_grbx_hdr[b]);
                    for (int b = 0; b < 64; b++) q.push_back(i_grbx_data[b]);
                end
                for (int b = 0; b < 64; b++) exp_data[b] = q.pop_front();
            end
            n_run++;
            exp_en = (((n_run - 1) % 33) != 32);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_pma_data", o_pma_data, exp_data);
            chk("model_clk_en", {63'd0, o_clk_en}, {63'd0, exp_en});
        end
    end

    // Present a block once o_clk_en is high; pause cycles get random junk.
    task automatic send(input logic [1:0] h, input logic [63:0] d);
        int guard = 0;
        while (!o_clk_en && guard < 4) begin
            i_grbx_hdr  = 2'($urandom);
            i_grbx_data = {$urandom, $urandom};
            @(negedge clk);
            guard++;
        end
        if (!o_clk_en) chk("send_timeout_clk_en", {63'd0, o_clk_en}, 64'd1);
        i_grbx_hdr  = h;
        i_grbx_data = d;
        @(negedge clk);
    endtask

    task automatic restart();
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int lows, misplaced;

        i_reset     = 1'b1;
        i_grbx_hdr  = '0;
        i_grbx_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_pma_data", o_pma_data, 64'd0);
        chk("reset_clk_en", {63'd0, o_clk_en}, 64'd0);

        // Single and second word.
        i_reset = 1'b0;
        @(negedge clk);
        chk("clk_en_after_release", {63'd0, o_clk_en}, 64'd1);
        chk("pma_zero_before_first", o_pma_data, 64'd0);
        i_grbx_hdr  = 2'b01;
        i_grbx_data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("word1", o_pma_data, 64'hFFFF_FFFF_FFFF_FFFD);
        i_grbx_hdr  = 2'b10;
        i_grbx_data = 64'h0;
        @(negedge clk);
        chk("word2", o_pma_data, 64'h0000_0000_0000_000B);

        // Wrap integrity.
        restart();
        for (int i = 0; i < 32; i++) begin
            send(2'b01, 64'hA5A5_A5A5_A5A5_A5A5);
            if (i == 0) chk("wrap_word1", o_pma_data, 64'h9696_9696_9696_9695);
        end
        chk("wrap_pause_en", {63'd0, o_clk_en}, 64'd0);
        i_grbx_hdr  = 2'b11;
        i_grbx_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        chk("wrap_word33", o_pma_data, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("wrap_resume_en", {63'd0, o_clk_en}, 64'd1);
        send(2'b10, 64'h0000_0000_0000_0003);
        chk("wrap_word34", o_pma_data, 64'h0000_0000_0000_000E);

        // Reset at seq=17.
        restart();
        for (int i = 0; i < 17; i++) send(2'($urandom), {$urandom, $urandom});
        i_reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_pma_data", o_pma_data, 64'd0);
        chk("mid_reset_clk_en", {63'd0, o_clk_en}, 64'd0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", o_pma_data, 64'd0);
        d = {$urandom, $urandom};
        send(2'b10, d);
        chk("post_reset_hdr", {62'd0, o_pma_data[1:0]}, 64'd2);
        chk("post_reset_payload", {2'b00, o_pma_data[63:2]}, {2'b00, d[61:0]});

        // Pause cadence over 200 run cycles, inputs random every cycle.
        restart();
        lows = 0;
        misplaced = 0;
        for (int r = 1; r <= 200; r++) begin
            if (!o_clk_en) begin
                lows++;
                if (r % 33 != 0) misplaced++;
            end
            i_grbx_hdr  = 2'($urandom);
            i_grbx_data = {$urandom, $urandom};
            @(negedge clk);
        end
        chk("cadence_low_count", 64'(lows), 64'd6);
        chk("cadence_misplaced", 64'(misplaced), 64'd0);

        // Long random stream with occasional resets; model checks each cycle.
        for (int c = 0; c < 3000; c++) begin
            i_reset     = ($urandom_range(0, 499) == 0);
            i_grbx_hdr  = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            i_grbx_data = {$urandom, $urandom};
            @(negedge clk);
        end
        i_reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_pcs_tx_gearbox.md
Name: eth_pcs_tx_gearbox

Overview:
TX-direction 66b-to-64b gearbox of the 10GBASE-R PCS, the inverse of the RX gearbox. Accepts one 66-bit block per enabled cycle as a 2-bit sync header plus 64 bits of scrambled payload. Emits a continuous 64-bit PMA word every cycle.
Throttles the upstream encoder/scrambler through o_clk_en: 32 blocks accepted per 33 output words. Sits between the TX scrambler and the PMA/serdes in the TX PCS top.

Parameters:
W_DATA, 64 (from eth_pcs_params), payload and PMA word width; only 64 supported.
W_SYNC, 2 (from eth_pcs_params), sync header width.
N_GRBX_SEQ, 33 (localparam), gearbox period in output words.

Ports:
i_clk  in  1  PCS TX clock (PMA word rate).
i_reset  in  1  synchronous, active-high reset.
i_grbx_hdr  in  W_SYNC  sync header of current block; 2'b01 = data, 2'b10 = control.
i_grbx_data  in  W_DATA  scrambled payload of current block.
o_clk_en  out  1  high = block on i_grbx_* is consumed at this rising edge; upstream advances only when high.
o_pma_data  out  W_DATA  PMA word; bit 0 transmitted first.

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_reset). No other clocks or asynchronous logic.
- Bit order: the block is the 66-bit vector {i_grbx_data, i_grbx_hdr}; header occupies bits 1:0 and is transmitted first. Stream is LSB-first across words.
- State:
  - seq counter, 0..32.
  - residual register, up to 64 bits, valid bits LSB-aligned; it holds 2*seq valid bits.
  - run flag.
- Reset: seq=0, residual=0, run=0, o_pma_data=0, o_clk_en=0.
- run is set on the first cycle after i_reset deasserts. o_clk_en = run && (seq != 32), decoded from registered state, so there is no combinational path from the inputs.
- Cycle with seq = k < 32 and run = 1:
  - Form {block66, residual[2k-1:0]}, width 2k+66.
  - Low 64 bits are registered into o_pma_data.
  - Upper 2k+2 bits become the new residual.
  - seq <= k+1.
- Cycle with seq = 32:
  - o_clk_en = 0 and the inputs are ignored; any value on them has no effect.
  - o_pma_data <= residual (exactly 64 bits); residual <= 0; seq <= 0.
- Latency: a block's first bit appears in o_pma_data on the clock edge that consumes it (1-cycle register). After reset, the first valid PMA word is the cycle following the first o_clk_en=1 cycle.
- Period: o_clk_en is low for exactly 1 cycle in every 33 once run=1. No gaps in o_pma_data.
- Reset mid-operation (any seq):
  - All state returns to reset values on the same edge; partially sent block bits are discarded.
  - The first block after reset starts at bit 0 of a word. The RX side relocks.
- i_reset held high: o_pma_data remains 0 and no blocks are consumed.
- Wrap: seq 32 -> 0 with an empty residual; no bit is lost or duplicated across the wrap.
- Width rule: the shift/select is a variable-offset mux indexed by 2*seq (0..62). The implementation must not infer a 128-bit barrel shifter per bit beyond this range.

Decomposition:
- eth_pcs_params holds W_DATA, W_SYNC, N_GRBX_SEQ (=33), and the sync header constants SYNC_DATA=2'b01 and SYNC_CTRL=2'b10, shared with the RX gearbox and the 66/64 encoder/decoder.
- No sub-module: counter, residual and output mux form one block.
- The TX PCS top instantiates the encoder, then the scrambler (SCR_MODE=0), then this gearbox, with o_clk_en driving the upstream clock enables.

Test Plan:
- Single word: reset, release, present hdr=2'b01, data=64'hFFFF_FFFF_FFFF_FFFF -> o_pma_data=64'hFFFF_FFFF_FFFF_FFFD; residual=2'b11.
- Second word: next block hdr=2'b10, data=0 -> o_pma_data=64'h0000_0000_0000_000B.
- Pause cadence: 200 cycles after reset -> o_clk_en low at run-cycles 33, 66, 99, ... exactly one cycle each.
  - Toggle the inputs to random values in the pause cycles -> the output stream is unchanged versus a quiet-input run.
- Wrap integrity: 32 blocks of data=64'hA5A5_A5A5_A5A5_A5A5, hdr=2'b01 -> the 33rd word equals block 31 bits 65:2 = 64'hA5A5_A5A5_A5A5_A5A5; the next word starts with the header of block 32.
- Round trip: loop o_pma_data into eth_pcs_rx_gearbox and feed 5000 random blocks -> after the RX reports header lock, recovered hdr/data match the sent blocks in order with zero mismatches.
- Reset at seq=17: assert i_reset for 1 cycle -> o_pma_data=0 and o_clk_en=0 during reset; the first post-reset word begins with the new block's header at bits 1:0.
